quad_gather: RTL
================

QUAD_GATHER -- requirements
Module: quad_gather

Interface
REQ-001 Parameter DSIZE, default 64: operand width in bits.
REQ-002 Parameter LAT, default 2: register latency of the downstream 4-input adder, used to align sum_valid.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_data  input  DSIZE  operand word from the upstream stream.
REQ-006 in_valid  input  1  in_data holds a word.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 flush  input  1  request to issue a partially filled group.
REQ-009 out_a, out_b, out_c, out_d  output  DSIZE each  operand registers driving the adder inputs in_a..in_d.
REQ-010 out_valid  output  1  one-cycle pulse; out_a..out_d hold a newly issued group.
REQ-011 sum_valid  output  1  out_valid delayed LAT cycles; marks the cycle in which the adder's sum output holds that group's result.
REQ-012 grp_cnt  output  16  number of groups issued, modulo 2^16.
REQ-013 fill_lvl  output  2  number of words currently staged (0..3).

Function
REQ-014 A word shall be accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-015 in_ready shall be 0 during reset, then 1 on every cycle from the first edge after reset release; it depends on no other input.
REQ-016 Accepted words shall fill staging slots in order: the first word goes to A, then B, then C, then D. The slot pointer shall advance by 1 per accepted word.
REQ-017 When a word fills slot D, the cycle after acceptance shall load out_a..out_d from the four staged words and pulse out_valid for exactly one cycle. The pointer shall return to A.
REQ-018 out_a..out_d shall change only in issue cycles; between issues they shall hold their values while staging continues.
REQ-019 Staging shall use registers separate from out_a..out_d, so back-to-back groups issue every 4 accepted words with no bubble.
REQ-020 flush=1 with fill_lvl>0 and no word accepted shall issue the staged words in their slots, with unfilled slots set to zero. Issue timing shall be as in REQ-017, and the pointer shall reset to A.
REQ-021 flush=1 in the same cycle as an accepted word: the word shall be staged first, then the group issued with the remaining slots zeroed. If that word fills D, exactly one group shall issue.
REQ-022 flush=1 with fill_lvl=0 and no accepted word shall be ignored: no issue and no state change.
REQ-023 grp_cnt shall increment by 1 per out_valid pulse and wrap from 65535 to 0.
REQ-024 sum_valid shall be a LAT-deep shift of out_valid, with no gaps or merging of back-to-back pulses.
REQ-025 fill_lvl shall equal the slot pointer value; it shall read 0 immediately after any issue.

Reset
REQ-026 Asserting rst_n low shall asynchronously clear the staging slots, pointer, out_a..out_d, out_valid, the sum_valid shift chain, grp_cnt and in_ready to 0.
REQ-027 Reset mid-group shall discard staged words with no issue. Reset during an in-flight sum_valid pulse shall cancel it.

Structure
REQ-028 Shared package shall hold the DSIZE and LAT defaults and the slot index constants (SLOT_A..SLOT_D = 0..3).
REQ-029 The sum_valid delay shall be a sub-module valid_delay, parameterised by depth, with clk, rst_n, d and q ports.
REQ-030 The datapath shall have no arithmetic except the pointer and grp_cnt increments.

Verification
REQ-031 Accept 1,2,3,4 on consecutive cycles -> out_a..d=1,2,3,4; out_valid pulses 1 cycle after word 4; sum_valid pulses 2 cycles later; the adder sum shows 10 in that cycle.
REQ-032 Stream 8 words 1..8 back-to-back -> two out_valid pulses 4 cycles apart, groups (1,2,3,4) and (5,6,7,8); grp_cnt=2.
REQ-033 Accept 7,9, then flush alone -> out_a..d=7,9,0,0; one pulse; fill_lvl=0 afterwards.
REQ-034 Accept 1,2,3, then word 4 with flush in the same cycle -> exactly one issue (1,2,3,4). A later flush with fill_lvl=0 -> no pulse.
REQ-035 Preload grp_cnt to 65535 via 65535 groups (or force), issue one group -> grp_cnt=0.
REQ-036 Accept 2 words, then pulse rst_n low mid-cycle -> all outputs 0 immediately. Then 4 new words -> the issued group contains only the new words.

Source files
------------

// File: rtl/quad_gather_pkg.sv
// quad_gather_pkg: shared defaults and slot index constants for the quad_gather block
package quad_gather_pkg;
  localparam int DSIZE_DEF = 64;
  localparam int LAT_DEF = 2;
  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;
endpackage

// File: rtl/valid_delay.sv
// valid_delay: DEPTH-cycle shift of a 1-bit strobe; ports clk, rst_n (async low), d in, q out
module valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_shift
      logic [DEPTH-1:0] sh;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sh <= '0;
        else sh <= DEPTH'({sh, d});
      assign q = sh[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/quad_gather.sv
// quad_gather: stages a word stream into groups of four (A..D) feeding a 4-input adder; ports clk, rst_n, in_data/in_valid/in_ready, flush, out_a..out_d/out_valid, sum_valid, grp_cnt, fill_lvl
module quad_gather
  import quad_gather_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [DSIZE-1:0] out_a,
  output logic [DSIZE-1:0] out_b,
  output logic [DSIZE-1:0] out_c,
  output logic [DSIZE-1:0] out_d,
  output logic             out_valid,
  output logic             sum_valid,
  output logic [15:0]      grp_cnt,
  output logic [1:0]       fill_lvl
);
  logic [DSIZE-1:0] stage [4];
  logic [DSIZE-1:0] g_a, g_b, g_c, g_d;
  logic [1:0] ptr;
  logic acc, issue;
  assign acc = in_valid & in_ready;
  assign issue = (acc && ptr == SLOT_D) || (flush && (acc || ptr != SLOT_A));
  // Issued group: already-staged slots, the word arriving this cycle in its slot, zeros beyond it
  assign g_a = (ptr > SLOT_A) ? stage[SLOT_A] : (acc && ptr == SLOT_A) ? in_data : '0;
  assign g_b = (ptr > SLOT_B) ? stage[SLOT_B] : (acc && ptr == SLOT_B) ? in_data : '0;
  assign g_c = (ptr > SLOT_C) ? stage[SLOT_C] : (acc && ptr == SLOT_C) ? in_data : '0;
  assign g_d = (acc && ptr == SLOT_D) ? in_data : '0;
  assign fill_lvl = ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stage <= '{default: '0};
      ptr <= SLOT_A;
      in_ready <= 1'b0;
      out_a <= '0;
      out_b <= '0;
      out_c <= '0;
      out_d <= '0;
      out_valid <= 1'b0;
      grp_cnt <= '0;
    end else begin
      in_ready <= 1'b1;
      if (acc) stage[ptr] <= in_data;
      ptr <= issue ? SLOT_A : acc ? ptr + 2'd1 : ptr;
      out_valid <= issue;
      if (issue) begin
        out_a <= g_a;
        out_b <= g_b;
        out_c <= g_c;
        out_d <= g_d;
      end
      grp_cnt <= grp_cnt + 16'(issue);
    end
  valid_delay #(.DEPTH(LAT)) u_sum_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (out_valid),
    .q    (sum_valid)
  );
endmodule
